// File: rtl/axi_rr_bridge.sv
// Round-robin bridge: NUM_RD read masters and one write master onto a single AXI3 master port.
// Optional macro AXI_RESP_ERR_EN enables the sticky rd_err/wr_err response checks.
module axi_rr_bridge #(
    parameter int NUM_RD = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rset,
    // read masters
    input  logic [NUM_RD-1:0]        m_rd_req,
    input  logic [NUM_RD*ADDR_W-1:0] m_rd_addr,
    input  logic [NUM_RD*8-1:0]      m_rd_len,
    input  logic [NUM_RD-1:0]        m_rd_ready,
    output logic [NUM_RD-1:0]        m_rd_accept,
    output logic [NUM_RD-1:0]        m_rd_dvalid,
    output logic [NUM_RD-1:0]        m_rd_last,
    output logic [DATA_W-1:0]        m_rd_data,
    // write master
    input  logic                     w_req,
    input  logic [ADDR_W-1:0]        w_addr,
    input  logic [7:0]               w_len,
    input  logic [DATA_W-1:0]        w_data,
    input  logic [DATA_W/8-1:0]      w_strb,
    input  logic                     w_dvalid,
    output logic                     w_accept,
    output logic                     w_dready,
    output logic                     w_done,
    output logic                     rd_err,
    output logic                     wr_err,
    // AXI3 master
    output logic [3:0]               arid,
    output logic [ADDR_W-1:0]        araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic [1:0]               arlock,
    output logic [3:0]               arcache,
    output logic [2:0]               arprot,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [3:0]               rid,
    input  logic [DATA_W-1:0]        rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    output logic [3:0]               awid,
    output logic [ADDR_W-1:0]        awaddr,
    output logic [7:0]               awlen,
    output logic [2:0]               awsize,
    output logic [1:0]               awburst,
    output logic [1:0]               awlock,
    output logic [3:0]               awcache,
    output logic [2:0]               awprot,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [3:0]               wid,
    output logic [DATA_W-1:0]        wdata,
    output logic [DATA_W/8-1:0]      wstrb,
    output logic                     wlast,
    output logic                     wvalid,
    input  logic                     wready,
    input  logic [3:0]               bid,
    input  logic [1:0]               bresp,
    input  logic                     bvalid,
    output logic                     bready
);

    localparam int unsigned NR     = NUM_RD;
    localparam int          GW     = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam logic [2:0]  AXSIZE = 3'($clog2(DATA_W / 8));

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;

    rd_state_e         rd_state_q;
    logic [GW-1:0]     grant_q, last_grant_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [7:0]        rd_len_q;
    logic              arvalid_q;

    logic              hi_found, lo_found;
    logic [GW-1:0]     hi_idx, lo_idx, sel_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_len;
    logic              r_hs;

    wr_state_e         wr_state_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_len_q, wr_cnt_q;
    logic              awvalid_q, bready_q, w_done_q;
    logic              w_hs;

    // Round robin: first requester above last_grant wins, else wrap to the lowest requester.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (m_rd_req[i]) begin
                if (!hi_found && (GW'(i) > last_grant_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = GW'(i);
                end
                if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = GW'(i);
                end
            end
        end
        sel_idx  = hi_found ? hi_idx : lo_idx;
        sel_addr = '0;
        sel_len  = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (sel_idx == GW'(i)) begin
                sel_addr = m_rd_addr[i*ADDR_W +: ADDR_W];
                sel_len  = m_rd_len[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rset) begin
            rd_state_q   <= R_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_RD - 1);
            rd_addr_q    <= '0;
            rd_len_q     <= '0;
            arvalid_q    <= 1'b0;
        end else begin
            case (rd_state_q)
                R_IDLE: if (|m_rd_req) begin
                    grant_q    <= sel_idx;
                    rd_addr_q  <= sel_addr;
                    rd_len_q   <= sel_len;
                    arvalid_q  <= 1'b1;
                    rd_state_q <= R_ADDR;
                end
                R_ADDR: if (arready) begin
                    arvalid_q  <= 1'b0;
                    rd_state_q <= R_DATA;
                end
                R_DATA: if (r_hs && rlast) begin
                    last_grant_q <= grant_q;
                    rd_state_q   <= R_IDLE;
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    assign rready = (rd_state_q == R_DATA) && m_rd_ready[grant_q];
    assign r_hs   = rvalid && rready;

    always_comb begin
        m_rd_accept = '0;
        m_rd_dvalid = '0;
        m_rd_last   = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (grant_q == GW'(i)) begin
                m_rd_accept[i] = (rd_state_q == R_ADDR) && arvalid_q && arready;
                m_rd_dvalid[i] = (rd_state_q == R_DATA) && rvalid;
                m_rd_last[i]   = (rd_state_q == R_DATA) && rlast;
            end
        end
    end

    assign m_rd_data = rdata;
    assign arid      = 4'(grant_q);
    assign araddr    = rd_addr_q;
    assign arlen     = rd_len_q;
    assign arsize    = AXSIZE;
    assign arburst   = 2'b01;
    assign arlock    = 2'b00;
    assign arcache   = 4'b0000;
    assign arprot    = 3'b000;
    assign arvalid   = arvalid_q;

    always_ff @(posedge clk) begin
        if (rset) begin
            wr_state_q <= W_IDLE;
            wr_addr_q  <= '0;
            wr_len_q   <= '0;
            wr_cnt_q   <= '0;
            awvalid_q  <= 1'b0;
            bready_q   <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            w_done_q <= 1'b0;
            case (wr_state_q)
                W_IDLE: if (w_req) begin
                    wr_addr_q  <= w_addr;
                    wr_len_q   <= w_len;
                    awvalid_q  <= 1'b1;
                    wr_state_q <= W_ADDR;
                end
                W_ADDR: if (awready) begin
                    awvalid_q  <= 1'b0;
                    wr_cnt_q   <= '0;
                    wr_state_q <= W_DATA;
                end
                W_DATA: if (w_hs) begin
                    if (wlast) begin
                        bready_q   <= 1'b1;
                        wr_state_q <= W_RESP;
                    end else begin
                        wr_cnt_q <= wr_cnt_q + 8'd1;
                    end
                end
                W_RESP: if (bvalid) begin
                    bready_q   <= 1'b0;
                    w_done_q   <= 1'b1;
                    wr_state_q <= W_IDLE;
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    assign wvalid   = (wr_state_q == W_DATA) && w_dvalid;
    assign w_dready = (wr_state_q == W_DATA) && wready;
    assign wlast    = (wr_state_q == W_DATA) && (wr_cnt_q == wr_len_q);
    assign w_hs     = wvalid && wready;
    assign w_accept = awvalid_q && awready;
    assign w_done   = w_done_q;
    assign bready   = bready_q;
    assign wdata    = w_data;
    assign wstrb    = w_strb;
    assign wid      = 4'd0;
    assign awid     = 4'd0;
    assign awaddr   = wr_addr_q;
    assign awlen    = wr_len_q;
    assign awsize   = AXSIZE;
    assign awburst  = 2'b01;
    assign awlock   = 2'b00;
    assign awcache  = 4'b0000;
    assign awprot   = 3'b000;
    assign awvalid  = awvalid_q;

`ifdef AXI_RESP_ERR_EN
    logic rd_err_q, wr_err_q;

    always_ff @(posedge clk) begin
        if (rset) begin
            rd_err_q <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            if (r_hs && ((rresp != 2'b00) || (rid != 4'(grant_q)))) rd_err_q <= 1'b1;
            if (bvalid && bready_q && (bresp != 2'b00)) wr_err_q <= 1'b1;
        end
    end

    assign rd_err = rd_err_q;
    assign wr_err = wr_err_q;

    logic unused_bid;
    assign unused_bid = ^bid;
`else
    assign rd_err = 1'b0;
    assign wr_err = 1'b0;

    logic unused_resp;
    assign unused_resp = ^{rresp, rid, bresp, bid};
`endif

endmodule
